pwm_multi: RTL and testbench

Multi-channel PWM generator that replaces the single-channel, fixed-8-bit, free-running-period generator. It drives CHANNELS GPIO lines from one shared timebase, with a programmable period, a clock prescaler, edge- or center-aligned counting, and per-channel double-buffered duty registers. Duty and period changes take effect only at a period boundary, so no output ever produces a runt pulse. It sits between the register/control logic and the GPIO pins.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_channel.sv | 41 ++++
 rtl/pwm_multi.sv | 106 ++++++++++
 tb/tb_pwm_multi.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and width helpers for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Index width that never collapses to zero bits for a single channel.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: double-buffered duty (shadow -> active at period boundary),
// pending flag, compare against the shared counter, registered output.
module pwm_channel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             boundary,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic [WIDTH-1:0] cnt,
  output logic             gpio,
  output logic             pending
);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
      gpio    <= 1'b0;
    end else begin
      if (wr) shadow <= wr_duty;
      if (!en) begin
        active  <= shadow;
        pending <= 1'b0;
      end else begin
        // Transfer uses the pre-write shadow; a coincident write stays pending.
        if (boundary && pending) active <= shadow;
        if (wr) pending <= 1'b1;
        else if (boundary) pending <= 1'b0;
      end
      gpio <= en & (cnt < active);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaled timebase (edge/center aligned), shadowed
// period/mode, per-channel double-buffered duty, registered period_end pulse.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRESC_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        mode,
  input  logic [WIDTH-1:0]            period,
  input  logic [PRESC_W-1:0]          presc,
  // wr_en is a one-cycle write strobe: always accepted, no ready/backpressure.
  input  logic                        wr_en,
  input  logic [idx_w(CHANNELS)-1:0]  wr_ch,
  input  logic [WIDTH-1:0]            wr_duty,
  output logic [CHANNELS-1:0]         gpio,
  output logic [CHANNELS-1:0]         pending,
  output logic                        period_end,
  output logic [WIDTH-1:0]            dbg_cnt,
  output logic                        dbg_dir
);

  localparam int               CH_W = idx_w(CHANNELS);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [PRESC_W-1:0] presc_cnt;
  logic [WIDTH-1:0]   cnt, cnt_nxt, period_act;
  dir_e               dir, dir_nxt;
  mode_e              mode_act;
  logic               tick, boundary;

  assign tick    = en && (presc_cnt == presc);
  assign dbg_cnt = cnt;
  assign dbg_dir = dir;

  always_comb begin
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    boundary = 1'b0;
    if (!en) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (tick) begin
      if (period_act == '0)
        boundary = 1'b1;
      else if (mode_act == PWM_EDGE)
        boundary = (cnt == period_act);
      else
        // P=1 center: the top (cnt=1) is also the last tick of the period.
        boundary = (cnt == ONE) && ((dir == DIR_DOWN) || (period_act == ONE));

      if (boundary) begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
      end else if (dir == DIR_UP) begin
        if ((mode_act == PWM_CENTER) && (cnt == period_act)) begin
          cnt_nxt = cnt - ONE;
          dir_nxt = DIR_DOWN;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end else begin
        cnt_nxt = cnt - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_cnt  <= '0;
      cnt        <= '0;
      dir        <= DIR_UP;
      period_act <= '0;
      mode_act   <= PWM_EDGE;
      period_end <= 1'b0;
    end else begin
      presc_cnt  <= (!en || tick) ? '0 : presc_cnt + PRESC_W'(1);
      cnt        <= cnt_nxt;
      dir        <= dir_nxt;
      period_end <= boundary;
      if (!en || boundary) begin
        period_act <= period;
        mode_act   <= mode_e'(mode);
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .boundary (boundary),
      .wr       (wr_en && (wr_ch == CH_W'(i))),
      .wr_duty  (wr_duty),
      .cnt      (cnt),
      .gpio     (gpio[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: table of steady-state period/duty cases
// plus directed sequences for shadowing, coincident writes and async reset.
module tb_pwm_multi;
  import pwm_pkg::*;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int PRESC_W  = 8;
  localparam int NVEC     = 11;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic                 mode = 1'b0;
  logic [WIDTH-1:0]     period = '0;
  logic [PRESC_W-1:0]   presc = '0;
  logic                 wr_en = 1'b0;
  logic [1:0]           wr_ch = '0;
  logic [WIDTH-1:0]     wr_duty = '0;
  logic [CHANNELS-1:0]  gpio, pending;
  logic                 period_end;
  logic [WIDTH-1:0]     dbg_cnt;
  logic                 dbg_dir;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] dir_q[$];

  typedef struct {
    int mode;
    int period;
    int presc;
    int duty;
    int exp_len;
    int exp_high;
  } vec_t;
  vec_t vecs[NVEC];

  pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRESC_W(PRESC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .period     (period),
    .presc      (presc),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_duty    (wr_duty),
    .gpio       (gpio),
    .pending    (pending),
    .period_end (period_end),
    .dbg_cnt    (dbg_cnt),
    .dbg_dir    (dbg_dir)
  );

  // clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_duty(input int ch, input int d);
    wr_en   = 1'b1;
    wr_ch   = ch[1:0];
    wr_duty = d[WIDTH-1:0];
    step();
    wr_en   = 1'b0;
  endtask

  task automatic setup(input int m, input int p, input int ps, input int d);
    en     = 1'b0;
    mode   = m[0];
    period = p[WIDTH-1:0];
    presc  = ps[PRESC_W-1:0];
    write_duty(0, d);
    step();
    step();
  endtask

  task automatic wait_pe();
    int n = 0;
    while (!period_end && n < 400) begin
      step();
      n++;
    end
    check("wait_period_end", 32'(period_end), 1);
  endtask

  // Window starts at a period_end sample and runs to the next one.
  task automatic measure(input int ch, output int len, output int high);
    len  = 0;
    high = 0;
    wait_pe();
    if (!period_end) return;
    do begin
      high += int'(gpio[ch]);
      len++;
      step();
    end while (!period_end && len < 400);
  endtask

  initial begin
    int len, high;
    bit flag;

    vecs[0]  = '{0, 9, 0,   3, 10,  3};
    vecs[1]  = '{1, 4, 0,   2,  8,  3};
    vecs[2]  = '{0, 3, 2,   2, 12,  6};
    vecs[3]  = '{0, 9, 0,   0, 10,  0};
    vecs[4]  = '{0, 9, 0,  10, 10, 10};
    vecs[5]  = '{0, 9, 0, 255, 10, 10};
    vecs[6]  = '{0, 0, 0,   1,  1,  1};
    vecs[7]  = '{0, 0, 0,   0,  1,  0};
    vecs[8]  = '{1, 1, 0,   1,  2,  1};
    vecs[9]  = '{1, 3, 1,   4, 12, 12};
    vecs[10] = '{0, 5, 3,   3, 24, 12};

    // reset
    #2 rst = 1'b0;
    step();
    step();
    check("rst_gpio", 32'(gpio), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_period_end", 32'(period_end), 0);
    check("rst_cnt", 32'(dbg_cnt), 0);
    rst = 1'b1;
    step();

    // table-driven steady-state periods
    for (int i = 0; i < NVEC; i++) begin
      setup(vecs[i].mode, vecs[i].period, vecs[i].presc, vecs[i].duty);
      check($sformatf("v%0d_idle_pending", i), 32'(pending), 0);
      check($sformatf("v%0d_idle_gpio", i), 32'(gpio), 0);
      en = 1'b1;
      measure(0, len, high);
      check($sformatf("v%0d_len", i), len, vecs[i].exp_len);
      check($sformatf("v%0d_high", i), high, vecs[i].exp_high);
    end

    // center-aligned counter sequence
    setup(1, 4, 0, 2);
    en = 1'b1;
    wait_pe();
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    dir_q = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0};
    while (exp_q.size() > 0) begin
      check("center_cnt", 32'(dbg_cnt), 32'(exp_q.pop_front()));
      check("center_dir", 32'(dbg_dir), 32'(dir_q.pop_front()));
      step();
    end

    // mid-period duty write: current period keeps old duty
    setup(0, 9, 0, 3);
    en = 1'b1;
    wait_pe();
    check("mid_start_cnt", 32'(dbg_cnt), 0);
    high = 0;
    flag = 1'b1;
    for (int k = 0; k < 10; k++) begin
      high += int'(gpio[0]);
      if (k == 5) begin
        wr_en   = 1'b1;
        wr_ch   = 2'd0;
        wr_duty = 8'd7;
      end
      step();
      wr_en = 1'b0;
      if (k >= 5 && k < 9 && pending[0] !== 1'b1) flag = 1'b0;
    end
    check("mid_old_high", high, 3);
    check("mid_pending_held", 32'(flag), 1);
    check("mid_boundary_pe", 32'(period_end), 1);
    check("mid_pending_clr", 32'(pending[0]), 0);
    measure(0, len, high);
    check("mid_new_len", len, 10);
    check("mid_new_high", high, 7);

    // write coincident with boundary, prescaled
    setup(0, 3, 2, 2);
    en = 1'b1;
    wait_pe();
    for (int k = 0; k < 11; k++) begin
      if (k == 2) begin
        wr_en   = 1'b1;
        wr_ch   = 2'd0;
        wr_duty = 8'd1;
      end
      step();
      wr_en = 1'b0;
    end
    write_duty(0, 3);
    check("coin_pe", 32'(period_end), 1);
    check("coin_pending", 32'(pending[0]), 1);
    measure(0, len, high);
    check("coin_p1_len", len, 12);
    check("coin_p1_high", high, 3);
    check("coin_p1_pending", 32'(pending[0]), 0);
    measure(0, len, high);
    check("coin_p2_len", len, 12);
    check("coin_p2_high", high, 9);

    // async reset mid-period with gpio high
    write_duty(1, 5);
    check("pre_rst_pending", 32'(pending[1]), 1);
    for (int n = 0; n < 40 && gpio[0] !== 1'b1; n++) step();
    check("pre_rst_gpio", 32'(gpio[0]), 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_gpio", 32'(gpio), 0);
    check("async_rst_pending", 32'(pending), 0);
    #2 rst = 1'b1;
    period = 8'd9;
    presc  = '0;
    mode   = 1'b0;
    flag   = 1'b1;
    for (int n = 0; n < 25; n++) begin
      step();
      if (gpio !== '0) flag = 1'b0;
    end
    check("post_rst_low", 32'(flag), 1);
    write_duty(2, 5);
    measure(2, len, high);
    measure(2, len, high);
    check("post_rst_ch2_len", len, 10);
    check("post_rst_ch2_high", high, 5);
    check("post_rst_ch0_low", 32'(gpio[0]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
